// File: rtl/spi_pkg.sv
// Shared types and constants for the two-client SPI master.
package spi_pkg;

  // Transfer sequencer states, in the order a transfer walks through them.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_e;

  // SPI mode 0: clock idles low, data captured on the leading (rising) edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // Width of a counter that must hold 0 .. n-1; never narrower than one bit,
  // so a divide-by-one divider still has a legal register.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational; the caller owns the
// last_grant register and decides when a grant is actually taken.
module spi_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // Pick the requester: a lone request wins outright, a tie goes to the
  // client that was not served last.
  // NOTE: every output gets a default first so no path through this block
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req[1];
    end
    if (en && (req != 2'b00)) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_arb.sv
// Two-client SPI master, mode 0, MSB first, single slave select.
// Arbitrates round-robin between the clients and runs one full-duplex
// transfer per grant: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                busy,
  output logic                sclk,
  output logic                ss,
  output logic                mosi,
  input  logic                miso
);

  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int BIT_W = cnt_w(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [DATA_W-1:0] grant_data;
  logic [1:0]        rsp_valid_q;
  logic [1:0]        gnt;
  logic              gnt_idx;
  logic              last_grant_q;
  logic              sclk_q;
  logic              ss_q;
  logic              mosi_q;
  logic              arb_en;
  logic              accept;
  logic              div_last;
  logic              bit_last;
  logic              tick;
  logic              capture;
  logic              launch;
  logic              hold_done;

  // Grants are only offered while idle, and never while reset is held so
  // that no accept pulse is shown to a client during reset.
  assign arb_en = (state_q == IDLE) && rst_n;

  spi_rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign accept     = |gnt;
  assign grant_data = gnt_idx ? req_data[2*DATA_W-1 -: DATA_W] : req_data[DATA_W-1:0];

  // Divider and bit-counter terminal counts, and the two sclk edge types.
  // The leading edge (away from CPOL) captures miso in mode 0; the trailing
  // edge launches the next mosi bit.
  assign div_last  = (div_q == DIV_LAST);
  assign bit_last  = (bit_q == BIT_LAST);
  assign tick      = (state_q == XFER) && div_last;
  assign capture   = tick && ((sclk_q == CPOL) != CPHA);
  assign launch    = tick && !capture;
  assign hold_done = (state_q == HOLD) && div_last;

  // State register.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. SETUP, HOLD and GAP each last one divider period; XFER
  // ends on the trailing edge of the last bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)               state_d = SETUP;
      SETUP:   if (div_last)             state_d = XFER;
      XFER:    if (launch && bit_last)   state_d = HOLD;
      HOLD:    if (div_last)             state_d = GAP;
      GAP:     if (div_last)             state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Clock divider: free-runs through every non-idle state and restarts at
  // each state change, which always coincides with its terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if ((state_q == IDLE) || div_last) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Bit counter: counts trailing sclk edges within a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= '0;
    end else if (accept) begin
      bit_q <= '0;
    end else if (launch && !bit_last) begin
      bit_q <= bit_q + BIT_W'(1);
    end
  end

  // Round-robin memory: the client granted most recently. It also tags the
  // response, since only one transfer is ever in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= gnt_idx;
    end
  end

  // Transmit path: load the granted word and present its MSB at once, then
  // shift one bit per trailing edge; the last trailing edge does not shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      mosi_q <= 1'b0;
    end else if (accept) begin
      tx_q   <= grant_data;
      mosi_q <= grant_data[DATA_W-1];
    end else if (launch && !bit_last) begin
      tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
      mosi_q <= tx_q[DATA_W-2];
    end else if (hold_done) begin
      mosi_q <= 1'b0;
    end
  end

  // Receive path: miso enters at the LSB on each leading edge, so the first
  // (MSB) bit ends up at the top after DATA_W edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= '0;
    end else if (capture) begin
      rx_q <= {rx_q[DATA_W-2:0], miso};
    end
  end

  // SPI pins: sclk toggles on each divider tick in XFER; ss drops with the
  // grant and rises when HOLD finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= CPOL;
      ss_q   <= 1'b1;
    end else begin
      if (tick) begin
        sclk_q <= ~sclk_q;
      end
      if (accept) begin
        ss_q <= 1'b0;
      end else if (hold_done) begin
        ss_q <= 1'b1;
      end
    end
  end

  // Response: a one-cycle pulse to the granted client in the first GAP
  // cycle; rsp_data then holds until the next transfer completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      if (hold_done) begin
        rsp_valid_q[last_grant_q] <= 1'b1;
        rsp_data_q                <= rx_q;
      end
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign sclk      = sclk_q;
  assign ss        = ss_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb: a default instance (DATA_W=8, CLK_DIV=4) with a
// loopback / fixed-reply slave model and scoreboard, plus a CLK_DIV=1 instance.
module tb_spi_master_arb;

  localparam int DW    = 8;
  localparam int CD    = 4;
  localparam int LAT_A = 1 + (2*DW + 2) * CD;  // accept -> rsp_valid, 73
  localparam int GAP_A = 1 + (2*DW + 3) * CD;  // accept -> next accept, 77
  localparam int LAT_B = 1 + (2*DW + 2);       // 19 with CLK_DIV=1
  localparam int GAP_B = 1 + (2*DW + 3);       // 20 with CLK_DIV=1

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default parameters
  logic [1:0]    req_valid_a = 2'b00;
  logic [2*DW-1:0] req_data_a = '0;
  logic [1:0]    req_ready_a, rsp_valid_a;
  logic [DW-1:0] rsp_data_a;
  logic          busy_a, sclk_a, ss_a, mosi_a, miso_a;

  spi_master_arb #(.DATA_W(DW), .CLK_DIV(CD)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid_a),
    .req_data  (req_data_a),
    .req_ready (req_ready_a),
    .rsp_valid (rsp_valid_a),
    .rsp_data  (rsp_data_a),
    .busy      (busy_a),
    .sclk      (sclk_a),
    .ss        (ss_a),
    .mosi      (mosi_a),
    .miso      (miso_a)
  );

  // Instance B: divide-by-one sclk, loopback
  logic [1:0]    req_valid_b = 2'b00;
  logic [2*DW-1:0] req_data_b = '0;
  logic [1:0]    req_ready_b, rsp_valid_b;
  logic [DW-1:0] rsp_data_b;
  logic          busy_b, sclk_b, ss_b, mosi_b, miso_b;

  spi_master_arb #(.DATA_W(DW), .CLK_DIV(1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid_b),
    .req_data  (req_data_b),
    .req_ready (req_ready_b),
    .rsp_valid (rsp_valid_b),
    .rsp_data  (rsp_data_b),
    .busy      (busy_b),
    .sclk      (sclk_b),
    .ss        (ss_b),
    .mosi      (mosi_b),
    .miso      (miso_b)
  );

  assign miso_b = mosi_b;

  // Slave model for A: either loopback, or a mode-0 slave that presents
  // slv_word MSB first and advances one bit per falling sclk.
  logic          loopback = 1'b1;
  logic [DW-1:0] slv_word = '0;
  int            nfall = 0;

  always @(negedge sclk_a or posedge ss_a)
    if (ss_a) nfall <= 0;
    else      nfall <= nfall + 1;

  assign miso_a = loopback ? mosi_a : ((nfall < DW) ? slv_word[DW-1-nfall] : 1'b0);

  // Log of mosi as seen on every rising sclk of A.
  logic rise_log [256];
  int   rise_total = 0;
  always @(posedge sclk_a) begin
    rise_log[rise_total % 256] <= mosi_a;
    rise_total <= rise_total + 1;
  end

  // Scoreboard
  typedef struct {
    int            client;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t       sb[$];
  int         grant_log[$];
  int         accept_log[$];
  int         rsp_count = 0;
  logic [1:0] prev_rdy = 2'b00;
  bit         one_shot = 1'b1;
  int         checks = 0;
  int         errors = 0;

  // One clock of instance A: observe at negedge, push on accept, pop and
  // compare on response, then update stimulus just after the posedge.
  task automatic step();
    logic [1:0]    rdy, rv;
    logic [DW-1:0] rd;
    exp_t          e;
    @(negedge clk);
    rdy = req_ready_a;
    rv  = rsp_valid_a;
    rd  = rsp_data_a;
    if (rdy != 2'b00) begin
      checks++;
      if ($countones(rdy) != 1 || prev_rdy != 2'b00) begin
        errors++;
        $display("FAIL ready_pulse got req_ready=%b prev=%b, expected one-hot single-cycle", rdy, prev_rdy);
      end
      for (int i = 0; i < 2; i++) begin
        if (rdy[i]) begin
          e.client = i;
          e.data   = loopback ? req_data_a[i*DW +: DW] : slv_word;
          e.due    = cyc + LAT_A;
          sb.push_back(e);
          grant_log.push_back(i);
          accept_log.push_back(cyc);
        end
      end
    end
    prev_rdy = rdy;
    if (rv != 2'b00) begin
      rsp_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got rsp_valid=%b data=%h, expected no response", rv, rd);
      end else begin
        e = sb.pop_front();
        if (rv !== (2'b01 << e.client) || rd !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL rsp got valid=%b data=%h cycle=%0d, expected valid=%b data=%h cycle=%0d",
                   rv, rd, cyc, 2'b01 << e.client, e.data, e.due);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rdy[i]) begin
        if (one_shot) req_valid_a[i] = 1'b0;
        else          req_data_a[i*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(req_valid_a == 2'b00 && sb.size() == 0 && !busy_a)) begin
      if (n == budget) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout got %0d pending after %0d cycles, expected 0", sb.size(), budget);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready_a, rsp_valid_a, busy_a, sclk_a, ss_a, mosi_a} !== 8'b0000_0010) begin
      errors++;
      $display("FAIL reset_ctrl_a got rdy=%b rv=%b busy=%b sclk=%b ss=%b mosi=%b, expected 00 00 0 0 1 0",
               req_ready_a, rsp_valid_a, busy_a, sclk_a, ss_a, mosi_a);
    end
    checks++;
    if (rsp_data_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_a got %h, expected 00", rsp_data_a);
    end
    checks++;
    if ({req_ready_b, rsp_valid_b, busy_b, sclk_b, ss_b, mosi_b, rsp_data_b} !== {8'b0000_0010, 8'h00}) begin
      errors++;
      $display("FAIL reset_b got rdy=%b rv=%b busy=%b sclk=%b ss=%b mosi=%b data=%h, expected idle values",
               req_ready_b, rsp_valid_b, busy_b, sclk_b, ss_b, mosi_b, rsp_data_b);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_loopback();
    int            r0, c0;
    logic [DW-1:0] w;
    loopback = 1'b1;
    one_shot = 1'b1;
    w  = 8'hA5;
    r0 = rise_total;
    c0 = rsp_count;
    req_data_a[DW-1:0] = w;
    req_valid_a = 2'b01;
    drain(200);
    checks++;
    if (rise_total - r0 != DW || rsp_count - c0 != 1) begin
      errors++;
      $display("FAIL loopback_counts got rises=%0d rsps=%0d, expected %0d and 1", rise_total - r0, rsp_count - c0, DW);
    end
    for (int k = 0; k < DW; k++) begin
      checks++;
      if (rise_log[(r0 + k) % 256] !== w[DW-1-k]) begin
        errors++;
        $display("FAIL loopback_mosi bit %0d got %b, expected %b", k, rise_log[(r0 + k) % 256], w[DW-1-k]);
      end
    end
  endtask

  task automatic test_slave_reply();
    int r0;
    loopback = 1'b0;
    slv_word = 8'h3C;
    r0 = rise_total;
    req_data_a[2*DW-1:DW] = 8'hFF;
    req_valid_a = 2'b10;
    drain(200);
    checks++;
    if (rise_total - r0 != DW) begin
      errors++;
      $display("FAIL slave_rises got %0d, expected %0d", rise_total - r0, DW);
    end
    for (int k = 0; k < DW; k++) begin
      checks++;
      if (rise_log[(r0 + k) % 256] !== 1'b1) begin
        errors++;
        $display("FAIL slave_mosi bit %0d got %b, expected 1", k, rise_log[(r0 + k) % 256]);
      end
    end
    loopback = 1'b1;
  endtask

  task automatic test_round_robin();
    int n = 0;
    rst_n = 1'b0;
    req_data_a  = {8'h81, 8'h42};
    req_valid_a = 2'b11;
    #1;
    checks++;
    if (req_ready_a !== 2'b00) begin
      errors++;
      $display("FAIL ready_in_reset got %b, expected 00", req_ready_a);
    end
    sb.delete();
    prev_rdy = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    grant_log.delete();
    accept_log.delete();
    one_shot = 1'b0;
    while (!(grant_log.size() >= 4 && sb.size() == 0) && n < 500) begin
      step();
      n++;
    end
    req_valid_a = 2'b00;
    one_shot = 1'b1;
    checks++;
    if (n >= 500 || grant_log.size() != 4) begin
      errors++;
      $display("FAIL rr_timeout got %0d grants in %0d cycles, expected 4", grant_log.size(), n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_log[k] != (k % 2)) begin
          errors++;
          $display("FAIL rr_order grant %0d got client %0d, expected %0d", k, grant_log[k], k % 2);
        end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (accept_log[k] - accept_log[k-1] != GAP_A) begin
          errors++;
          $display("FAIL rr_spacing grant %0d got %0d cycles, expected %0d", k, accept_log[k] - accept_log[k-1], GAP_A);
        end
      end
    end
    drain(200);
  endtask

  task automatic test_reset_mid_xfer();
    int r0, c0;
    int n = 0;
    r0 = rise_total;
    req_data_a[DW-1:0] = 8'h5A;
    req_valid_a = 2'b01;
    while ((rise_total - r0) < 4 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL midrst_timeout got %0d rises, expected 4", rise_total - r0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ss_a !== 1'b1 || sclk_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pins got ss=%b sclk=%b busy=%b, expected 1 0 0", ss_a, sclk_a, busy_a);
    end
    sb.delete();
    prev_rdy = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    c0 = rsp_count;
    repeat (100) step();
    checks++;
    if (rsp_count != c0) begin
      errors++;
      $display("FAIL midrst_rsp got %0d responses, expected 0", rsp_count - c0);
    end
    req_data_a[2*DW-1:DW] = 8'h96;
    req_valid_a = 2'b10;
    drain(200);
    checks++;
    if (rsp_count != c0 + 1) begin
      errors++;
      $display("FAIL midrst_recover got %0d responses, expected 1", rsp_count - c0);
    end
  endtask

  task automatic test_req_during_xfer();
    grant_log.delete();
    accept_log.delete();
    req_data_a[DW-1:0] = 8'h11;
    req_valid_a = 2'b01;
    repeat (12) step();
    req_data_a[2*DW-1:DW] = 8'h22;
    req_valid_a[1] = 1'b1;
    drain(300);
    checks++;
    if (grant_log.size() != 2) begin
      errors++;
      $display("FAIL late_req_grants got %0d, expected 2", grant_log.size());
    end else begin
      checks++;
      if (grant_log[0] != 0 || grant_log[1] != 1 || accept_log[1] - accept_log[0] != GAP_A) begin
        errors++;
        $display("FAIL late_req got order %0d,%0d spacing %0d, expected 0,1 spacing %0d",
                 grant_log[0], grant_log[1], accept_log[1] - accept_log[0], GAP_A);
      end
    end
  endtask

  task automatic test_clkdiv1();
    int            acc_cyc[$], acc_idx[$], rsp_cyc[$], rsp_idx[$];
    logic [DW-1:0] acc_dat[$], rsp_dat[$];
    int            hi_cnt = 0, rise_cnt = 0, ss_run = 0, min_run = 1000;
    logic          sclk_prev = 1'b0, seen_low = 1'b0;
    logic [1:0]    rdy;
    req_data_b  = {8'h7E, 8'hC3};
    req_valid_b = 2'b11;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      rdy = req_ready_b;
      for (int i = 0; i < 2; i++) begin
        if (rdy[i]) begin
          acc_cyc.push_back(cyc);
          acc_idx.push_back(i);
          acc_dat.push_back(req_data_b[i*DW +: DW]);
        end
        if (rsp_valid_b[i]) begin
          rsp_cyc.push_back(cyc);
          rsp_idx.push_back(i);
          rsp_dat.push_back(rsp_data_b);
        end
      end
      if (sclk_b) hi_cnt++;
      if (sclk_b && !sclk_prev) rise_cnt++;
      sclk_prev = sclk_b;
      if (ss_b) begin
        if (seen_low) ss_run++;
      end else begin
        if (seen_low && ss_run > 0 && ss_run < min_run) min_run = ss_run;
        seen_low = 1'b1;
        ss_run = 0;
      end
      @(posedge clk);
      #1 req_valid_b = req_valid_b & ~rdy;
    end
    checks++;
    if (acc_cyc.size() != 2 || rsp_cyc.size() != 2) begin
      errors++;
      $display("FAIL div1_counts got accepts=%0d rsps=%0d, expected 2 and 2", acc_cyc.size(), rsp_cyc.size());
    end else begin
      checks++;
      if (acc_idx[0] != 0 || acc_idx[1] != 1 || acc_cyc[1] - acc_cyc[0] != GAP_B) begin
        errors++;
        $display("FAIL div1_grants got %0d,%0d spacing %0d, expected 0,1 spacing %0d",
                 acc_idx[0], acc_idx[1], acc_cyc[1] - acc_cyc[0], GAP_B);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rsp_idx[k] != acc_idx[k] || rsp_dat[k] !== acc_dat[k] || rsp_cyc[k] - acc_cyc[k] != LAT_B) begin
          errors++;
          $display("FAIL div1_rsp %0d got client=%0d data=%h latency=%0d, expected client=%0d data=%h latency=%0d",
                   k, rsp_idx[k], rsp_dat[k], rsp_cyc[k] - acc_cyc[k], acc_idx[k], acc_dat[k], LAT_B);
        end
      end
    end
    checks++;
    if (hi_cnt != 2*DW || rise_cnt != 2*DW) begin
      errors++;
      $display("FAIL div1_sclk got high=%0d rises=%0d, expected %0d and %0d", hi_cnt, rise_cnt, 2*DW, 2*DW);
    end
    checks++;
    if (min_run < 1 || min_run == 1000) begin
      errors++;
      $display("FAIL div1_ss_gap got %0d, expected at least 1 cycle high", min_run);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave_reply();
    test_round_robin();
    test_reset_mid_xfer();
    test_req_during_xfer();
    test_clkdiv1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
